// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared constants and types for the RGB PWM driver.
//   MODE_STATIC / MODE_BREATHE : encodings of the mode input
//   br_state_e                 : breathe ramp direction (UP / DOWN)
package rgb_pwm_pkg;

  localparam logic MODE_STATIC  = 1'b0;
  localparam logic MODE_BREATHE = 1'b1;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED output. Compares the shared PWM counter with this
// channel's effective duty and registers the result with pin polarity applied.
//   clk, rst_n : clock, asynchronous active-low reset (pin forced unlit)
//   cnt_i      : shared PWM counter
//   eff_i      : effective duty for this channel
//   led_o      : registered LED pin
module pwm_channel #(
  parameter int WIDTH      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] eff_i,
  output logic             led_o
);

  logic lit;
  logic led_d, led_q;

  // Strict less-than in WIDTH bits: duty 0 never lights, max duty lights
  // all but the last step, and nothing can overflow.
  assign lit   = (cnt_i < eff_i);
  assign led_d = lit ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= ACTIVE_LOW;
    else        led_q <= led_d;
  end

  assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: multi-channel LED PWM with shadowed duty registers and a
// shared breathe ramp.
//   clk, rst_n   : clock, asynchronous active-low reset
//   duty_in      : packed per-channel duty, channel 0 in the LSBs
//   duty_load    : one-cycle strobe writing duty_in into the shadow registers
//   mode         : 0 = static duty, 1 = breathe (sampled at period wrap)
//   led          : LED pins, polarity set by ACTIVE_LOW
//   period_start : one-clock pulse aligned with the first led cycle of a period
//
// Breathe FSM (steps only on a wrap that enters a breathe period)
//   state   | meaning
//   BR_UP   | level ramps up, turns at the maximum
//   BR_DOWN | level ramps down, turns at zero
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 12,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] duty_in,
  input  logic                 duty_load,
  input  logic                 mode,
  output logic [NCH-1:0]       led,
  output logic                 period_start
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] LVL_TOP1 = CNT_MAX - 1'b1;
  localparam logic [WIDTH-1:0] LVL_ONE  = WIDTH'(1);

  logic [PW-1:0]                presc_q, presc_d;
  logic [WIDTH-1:0]             cnt_q, cnt_d;
  logic [NCH-1:0][WIDTH-1:0]    shadow_q, shadow_d;
  logic [NCH-1:0][WIDTH-1:0]    act_q, act_d;
  logic                         mode_q, mode_d;
  logic                         ps_q, ps_d;
  logic [WIDTH-1:0]             level_q;
  br_state_e                    br_q;
  logic [NCH-1:0][WIDTH-1:0]    eff;
  logic                         tick;
  logic                         wrap;

  assign tick = (presc_q == PRE_LAST);
  assign wrap = tick && (cnt_q == CNT_MAX);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
    shadow_d = shadow_q;
    act_d    = act_q;
    mode_d   = mode_q;
    // The counters sit at zero exactly once per period, so this marks the
    // clock whose compare result becomes the first led cycle of the period.
    ps_d     = (presc_q == '0) && (cnt_q == '0);
    for (int ch = 0; ch < NCH; ch++) begin
      if (duty_load) shadow_d[ch] = duty_in[ch*WIDTH +: WIDTH];
      // A load landing on the wrap cycle bypasses the shadow so it is not
      // deferred by a whole period.
      if (wrap) act_d[ch] = duty_load ? duty_in[ch*WIDTH +: WIDTH] : shadow_q[ch];
    end
    if (wrap) mode_d = mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      act_q    <= '0;
      mode_q   <= MODE_STATIC;
      ps_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      mode_q   <= mode_d;
      ps_q     <= ps_d;
    end
  end

  // Steps with the incoming mode so the first breathe period already shows
  // the advanced level; static periods leave level and direction frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q    <= BR_UP;
      level_q <= '0;
    end else if (wrap && (mode == MODE_BREATHE)) begin
      case (br_q)
        BR_UP: begin
          if (level_q == CNT_MAX) begin
            br_q    <= BR_DOWN;
            level_q <= level_q - 1'b1;
          end else begin
            level_q <= level_q + 1'b1;
            if (level_q == LVL_TOP1) br_q <= BR_DOWN;
          end
        end
        BR_DOWN: begin
          if (level_q == '0) begin
            br_q    <= BR_UP;
            level_q <= level_q + 1'b1;
          end else begin
            level_q <= level_q - 1'b1;
            if (level_q == LVL_ONE) br_q <= BR_UP;
          end
        end
        default: br_q <= BR_UP;
      endcase
    end
  end

  // In breathe mode the active duty only acts as a channel enable.
  always_comb begin
    eff = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mode_q == MODE_BREATHE) eff[ch] = (act_q[ch] != '0) ? level_q : '0;
      else                        eff[ch] = act_q[ch];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(
      .WIDTH      (WIDTH),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt_i (cnt_q),
      .eff_i (eff[g]),
      .led_o (led[g])
    );
  end

  assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
module tb_rgb_pwm_driver;

  localparam int NCH   = 3;
  localparam int WIDTH = 4;
  localparam int PER   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH*WIDTH-1:0] duty_in = '0;
  logic                 duty_load = 1'b0;
  logic                 mode = 1'b0;
  logic [NCH-1:0]       led;
  logic                 period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(
    .NCH        (NCH),
    .WIDTH      (WIDTH),
    .PRESCALE   (1),
    .ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty_in      (duty_in),
    .duty_load    (duty_load),
    .mode         (mode),
    .led          (led),
    .period_start (period_start)
  );

  typedef struct {
    logic [3:0] d2, d1, d0;
    int         e2, e1, e0;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns at the negedge where period_start is seen (led shows cnt 0).
  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts lit (low) cycles per channel over one period starting at the
  // current negedge; extra counts unexpected period_start pulses.
  task automatic count_here(output int l0, output int l1, output int l2, output int extra);
    l0 = 0; l1 = 0; l2 = 0; extra = 0;
    for (int c = 0; c < PER; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (period_start) extra++;
      end
      if (!led[0]) l0++;
      if (!led[1]) l1++;
      if (!led[2]) l2++;
    end
  endtask

  task automatic measure(input string name, input int e2, input int e1, input int e0);
    bit ok;
    int l0, l1, l2, x;
    wait_ps(ok);
    check({name, "_sync"}, ok, 1);
    count_here(l0, l1, l2, x);
    check({name, "_ch0"}, l0, e0);
    check({name, "_ch1"}, l1, e1);
    check({name, "_ch2"}, l2, e2);
    check({name, "_ps_once"}, x, 0);
  endtask

  vec_t vecs[5];

  initial begin
    bit ok;
    int bad, npulse, first_ps, last_ps, gap_bad, l, l0, l1, l2, x, e;

    vecs[0] = '{4'd15, 4'd8,  4'd0,  15, 8,  0};
    vecs[1] = '{4'd1,  4'd7,  4'd14, 1,  7,  14};
    vecs[2] = '{4'd0,  4'd0,  4'd15, 0,  0,  15};
    vecs[3] = '{4'd3,  4'd15, 4'd2,  3,  15, 2};
    vecs[4] = '{4'd10, 4'd10, 4'd10, 10, 10, 10};

    // Reset held, then idle with no load
    repeat (3) @(negedge clk);
    check("rst_led", led, 7);
    check("rst_ps", period_start, 0);
    rst_n = 1'b1;
    bad = 0; npulse = 0; first_ps = -1; last_ps = -1; gap_bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (led != 3'b111) bad++;
      if (period_start) begin
        if (first_ps < 0) first_ps = i;
        else if (i - last_ps != PER) gap_bad++;
        last_ps = i;
        npulse++;
      end
    end
    check("idle_led_unlit", bad, 0);
    check("idle_ps_count", npulse, 4);
    check("idle_ps_first", first_ps, 0);
    check("idle_ps_spacing", gap_bad, 0);

    // Static duty table: load mid-period, takes effect from next period
    for (int v = 0; v < 5; v++) begin
      wait_ps(ok);
      duty_in = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
      duty_load = 1'b1;
      @(negedge clk);
      duty_load = 1'b0;
      measure($sformatf("static%0d", v), vecs[v].e2, vecs[v].e1, vecs[v].e0);
    end

    // Two loads in one period: current period keeps 10, next uses 12
    wait_ps(ok);
    l = 0;
    for (int c = 0; c < PER; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        duty_in = {3{4'd4}};
        duty_load = 1'b1;
      end else if (c == 1) duty_load = 1'b0;
      else if (c == 9) begin
        duty_in = {3{4'd12}};
        duty_load = 1'b1;
      end else if (c == 10) duty_load = 1'b0;
      if (!led[1]) l++;
    end
    check("reload_cur_period", l, 10);
    measure("reload_next", 12, 12, 12);

    // Load coincident with the wrap cycle
    wait_ps(ok);
    for (int c = 1; c < PER; c++) begin
      @(negedge clk);
      if (c == 14) begin
        duty_in = {3{4'd5}};
        duty_load = 1'b1;
      end else if (c == 15) duty_load = 1'b0;
    end
    @(negedge clk);
    check("wrapload_ps", period_start, 1);
    count_here(l0, l1, l2, x);
    check("wrapload_ch0", l0, 5);
    check("wrapload_ch2", l2, 5);

    // Breathe ramp, ch0 masked off
    wait_ps(ok);
    duty_in = {4'd1, 4'd1, 4'd0};
    duty_load = 1'b1;
    mode = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    for (int p = 0; p < 30; p++) begin
      e = (p < 15) ? p + 1 : 29 - p;
      measure($sformatf("breathe%0d", p), e, e, 0);
    end
    // Period at level 1: mode drops mid-period, no visible change until wrap
    wait_ps(ok);
    l = 0;
    for (int c = 0; c < PER; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) begin
        mode = 1'b0;
        duty_in = {4'd7, 4'd7, 4'd0};
        duty_load = 1'b1;
      end else if (c == 6) duty_load = 1'b0;
      if (!led[2]) l++;
    end
    check("breathe_last_lvl1", l, 1);
    measure("static_pause", 7, 7, 0);
    wait_ps(ok);
    l = 0;
    for (int c = 0; c < PER; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) mode = 1'b1;
      if (!led[1]) l++;
    end
    check("static_pause2", l, 7);
    // Resume continues from level 1 going UP
    for (int p = 2; p < 9; p++) measure($sformatf("resume%0d", p), p, p, 0);

    // Reset mid-ramp at level 9
    wait_ps(ok);
    repeat (3) @(negedge clk);
    check("lvl9_lit_before_rst", led[1], 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 7);
    check("async_rst_ps", period_start, 0);
    mode = 1'b0;
    duty_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ps", period_start, 1);
    count_here(l0, l1, l2, x);
    check("post_rst_ch0", l0, 0);
    check("post_rst_ch1", l1, 0);
    check("post_rst_ch2", l2, 0);
    wait_ps(ok);
    duty_in = {4'd1, 4'd1, 4'd0};
    duty_load = 1'b1;
    mode = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    measure("post_rst_breathe", 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
